// File: rtl/pa_iu_mul_arb_if.sv
// Request/response/multiplier bundle for the shared multiplier arbiter.
// master = requesters + multiplier, slave = arbiter.
interface pa_iu_mul_arb_if;
  logic        req0_vld;
  logic [31:0] req0_src0;
  logic [31:0] req0_src1;
  logic [2:0]  req0_func;
  logic        req0_rdy;
  logic        req1_vld;
  logic [31:0] req1_src0;
  logic [31:0] req1_src1;
  logic [2:0]  req1_func;
  logic        req1_rdy;
  logic        rsp0_vld;
  logic        rsp0_rdy;
  logic        rsp1_vld;
  logic        rsp1_rdy;
  logic [31:0] rsp_rslt;
  logic        flush;
  logic        mul_ex1_sel;
  logic [31:0] mul_ex1_src0;
  logic [31:0] mul_ex1_src1;
  logic [2:0]  mul_ex1_func;
  logic        mul_ex2_stall;
  logic [31:0] mul_ex2_rslt;
  logic        arb_busy;

  modport master (
    output req0_vld, req0_src0, req0_src1, req0_func,
    output req1_vld, req1_src0, req1_src1, req1_func,
    output rsp0_rdy, rsp1_rdy, flush, mul_ex2_rslt,
    input  req0_rdy, req1_rdy, rsp0_vld, rsp1_vld,
    input  rsp_rslt, mul_ex1_sel, mul_ex1_src0,
    input  mul_ex1_src1, mul_ex1_func, mul_ex2_stall,
    input  arb_busy
  );

  modport slave (
    input  req0_vld, req0_src0, req0_src1, req0_func,
    input  req1_vld, req1_src0, req1_src1, req1_func,
    input  rsp0_rdy, rsp1_rdy, flush, mul_ex2_rslt,
    output req0_rdy, req1_rdy, rsp0_vld, rsp1_vld,
    output rsp_rslt, mul_ex1_sel, mul_ex1_src0,
    output mul_ex1_src1, mul_ex1_func, mul_ex2_stall,
    output arb_busy
  );
endinterface

// File: rtl/pa_iu_mul_arb.sv
// Two-requester arbiter/sequencer for the shared EX1/EX2 multiplier.
// Requester 0 has priority; a starvation counter guarantees requester 1.
module pa_iu_mul_arb #(
  parameter int unsigned STARVE_MAX = 3
) (
  input logic            forever_cpuclk,
  input logic            cpurst,
  pa_iu_mul_arb_if.slave mif
);

  logic       ex2_vld;
  logic       ex2_own;
  logic [3:0] starve_cnt;

  logic rsp_fire;
  logic slot_free;
  logic starved;
  logic pick0;
  logic pick1;
  logic gnt0;
  logic gnt1;

  always_comb begin
    rsp_fire  = ex2_vld &
                (ex2_own ? mif.rsp1_rdy : mif.rsp0_rdy);
    slot_free = !ex2_vld | rsp_fire;
    starved   = starve_cnt == 4'(STARVE_MAX);
    pick1     = mif.req1_vld &
                (!mif.req0_vld | starved | mif.flush);
    pick0     = mif.req0_vld & !mif.flush & !pick1;
    gnt0      = pick0 & slot_free & !cpurst;
    gnt1      = pick1 & slot_free & !cpurst;
  end

  always_comb begin
    mif.mul_ex1_src0 = '0;
    mif.mul_ex1_src1 = '0;
    mif.mul_ex1_func = '0;
    unique case (1'b1)
      gnt1: begin
        mif.mul_ex1_src0 = mif.req1_src0;
        mif.mul_ex1_src1 = mif.req1_src1;
        mif.mul_ex1_func = mif.req1_func;
      end
      gnt0: begin
        mif.mul_ex1_src0 = mif.req0_src0;
        mif.mul_ex1_src1 = mif.req0_src1;
        mif.mul_ex1_func = mif.req0_func;
      end
      default: ;
    endcase
  end

  assign mif.req0_rdy      = gnt0;
  assign mif.req1_rdy      = gnt1;
  assign mif.mul_ex1_sel   = gnt0 | gnt1;
  assign mif.mul_ex2_stall = ex2_vld & !rsp_fire & !cpurst;
  assign mif.rsp0_vld      = ex2_vld & !ex2_own &
                             !mif.flush & !cpurst;
  assign mif.rsp1_vld      = ex2_vld & ex2_own & !cpurst;
  assign mif.rsp_rslt      = mif.mul_ex2_rslt;
  assign mif.arb_busy      = ex2_vld | mif.req0_vld |
                             mif.req1_vld;

  // a flush only drops requester-0 work still parked in EX2
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ex2_vld <= 1'b0;
      ex2_own <= 1'b0;
    end else if (slot_free) begin
      ex2_vld <= gnt0 | gnt1;
      ex2_own <= gnt1;
    end else if (mif.flush & !ex2_own) begin
      ex2_vld <= 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      starve_cnt <= '0;
    end else if (gnt1 | !mif.req1_vld) begin
      starve_cnt <= '0;
    end else if (gnt0 & !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_pa_iu_mul_arb.sv
// Directed bench for pa_iu_mul_arb with a behavioural multiplier.
// Inputs change 1ns after the rising edge; outputs sampled mid-cycle.
module tb_pa_iu_mul_arb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pa_iu_mul_arb_if mif ();

  pa_iu_mul_arb #(.STARVE_MAX(3)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .mif            (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mul_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  f
  );
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = f[0] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = f[1] ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return f[2] ? p[31:0] : p[63:32];
  endfunction

  logic [31:0] mdl_r;
  always_ff @(posedge clk) begin
    if (!mif.mul_ex2_stall && mif.mul_ex1_sel)
      mdl_r <= mul_f(mif.mul_ex1_src0,
                     mif.mul_ex1_src1,
                     mif.mul_ex1_func);
  end
  assign mif.mul_ex2_rslt = mdl_r;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic idle();
    mif.req0_vld  = 1'b0;
    mif.req0_src0 = '0;
    mif.req0_src1 = '0;
    mif.req0_func = '0;
    mif.req1_vld  = 1'b0;
    mif.req1_src0 = '0;
    mif.req1_src1 = '0;
    mif.req1_func = '0;
    mif.rsp0_rdy  = 1'b1;
    mif.rsp1_rdy  = 1'b1;
    mif.flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    mif.req0_vld  = 1'b1;
    mif.req0_src0 = 32'd3;
    mif.req0_src1 = 32'd3;
    mif.req0_func = 3'b100;
    step();
    step();
    mid();
    checks++;
    if (mif.req0_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_rdy0 got=%b exp=0", mif.req0_rdy);
    end
    checks++;
    if (mif.mul_ex1_sel !== 1'b0) begin
      errors++;
      $display("FAIL rst_sel got=%b exp=0", mif.mul_ex1_sel);
    end
    checks++;
    if (mif.mul_ex1_src0 !== 32'd0) begin
      errors++;
      $display("FAIL rst_src0 got=%h exp=0", mif.mul_ex1_src0);
    end
    idle();
    step();
    rst = 1'b0;
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b0 || mif.rsp1_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_rspvld got=%b%b exp=00",
               mif.rsp0_vld, mif.rsp1_vld);
    end
    checks++;
    if (dut.starve_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_starve got=%0d exp=0", dut.starve_cnt);
    end
    step();
  endtask

  task automatic test_basic();
    idle();
    mif.req0_vld  = 1'b1;
    mif.req0_src0 = 32'h7;
    mif.req0_src1 = 32'h6;
    mif.req0_func = 3'b100;
    mid();
    checks++;
    if (mif.req0_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_rdy0 got=%b exp=1", mif.req0_rdy);
    end
    checks++;
    if (mif.mul_ex1_src0 !== 32'h7) begin
      errors++;
      $display("FAIL basic_src0 got=%h exp=7", mif.mul_ex1_src0);
    end
    checks++;
    if (mif.mul_ex1_func !== 3'b100) begin
      errors++;
      $display("FAIL basic_func got=%b exp=100", mif.mul_ex1_func);
    end
    step();
    idle();
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b1) begin
      errors++;
      $display("FAIL basic_rspvld got=%b exp=1", mif.rsp0_vld);
    end
    checks++;
    if (mif.rsp_rslt !== 32'h2A) begin
      errors++;
      $display("FAIL basic_rslt got=%h exp=2a", mif.rsp_rslt);
    end
    step();
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got=%b exp=0", mif.rsp0_vld);
    end
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    mif.req0_vld  = 1'b1;
    mif.req0_src0 = 32'd3;
    mif.req0_src1 = 32'd5;
    mif.req0_func = 3'b100;
    mid();
    checks++;
    if (mif.req0_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rdy_c0 got=%b exp=1", mif.req0_rdy);
    end
    step();
    mif.req0_src0 = 32'd4;
    mif.req0_src1 = 32'd9;
    mif.rsp0_rdy  = 1'b0;
    mid();
    checks++;
    if (mif.mul_ex2_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall_c1 got=%b exp=1", mif.mul_ex2_stall);
    end
    checks++;
    if (mif.req0_rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rdy_c1 got=%b exp=0", mif.req0_rdy);
    end
    step();
    mif.rsp0_rdy = 1'b1;
    mid();
    checks++;
    if (mif.req0_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rdy_c2 got=%b exp=1", mif.req0_rdy);
    end
    checks++;
    if (mif.rsp0_vld !== 1'b1 || mif.rsp_rslt !== 32'd15) begin
      errors++;
      $display("FAIL b2b_hold_c2 got=%b/%h exp=1/f",
               mif.rsp0_vld, mif.rsp_rslt);
    end
    checks++;
    if (mif.mul_ex2_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall_c2 got=%b exp=0", mif.mul_ex2_stall);
    end
    step();
    idle();
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b1 || mif.rsp_rslt !== 32'd36) begin
      errors++;
      $display("FAIL b2b_second got=%b/%h exp=1/24",
               mif.rsp0_vld, mif.rsp_rslt);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [4:0] g1;
    int         cnt[5];
    g1  = 5'b01000;
    cnt = '{1, 2, 3, 0, 1};
    idle();
    mif.req0_vld  = 1'b1;
    mif.req0_src0 = 32'd2;
    mif.req0_src1 = 32'd2;
    mif.req0_func = 3'b100;
    mif.req1_vld  = 1'b1;
    mif.req1_src0 = 32'd5;
    mif.req1_src1 = 32'd5;
    mif.req1_func = 3'b100;
    for (int i = 0; i < 5; i++) begin
      mid();
      checks++;
      if (mif.req1_rdy !== g1[i] || mif.req0_rdy !== !g1[i]) begin
        errors++;
        $display("FAIL starve_gnt[%0d] got=%b%b exp=%b%b", i,
                 mif.req1_rdy, mif.req0_rdy, g1[i], !g1[i]);
      end
      step();
      checks++;
      if (dut.starve_cnt !== 4'(cnt[i])) begin
        errors++;
        $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", i,
                 dut.starve_cnt, cnt[i]);
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_flush();
    idle();
    mif.req0_vld  = 1'b1;
    mif.req0_src0 = 32'd8;
    mif.req0_src1 = 32'd8;
    mif.req0_func = 3'b100;
    mif.rsp0_rdy  = 1'b0;
    step();
    mif.req0_vld = 1'b0;
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b1 || mif.mul_ex2_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got=%b%b exp=11",
               mif.rsp0_vld, mif.mul_ex2_stall);
    end
    step();
    mif.flush    = 1'b1;
    mif.req0_vld = 1'b1;
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_rsp0 got=%b exp=0", mif.rsp0_vld);
    end
    checks++;
    if (mif.req0_rdy !== 1'b0 || mif.mul_ex1_sel !== 1'b0) begin
      errors++;
      $display("FAIL flush_rdy0 got=%b%b exp=00",
               mif.req0_rdy, mif.mul_ex1_sel);
    end
    step();
    idle();
    mif.rsp0_rdy = 1'b0;
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b0 || mif.arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill got=%b/%b exp=0/0",
               mif.rsp0_vld, mif.arb_busy);
    end
    step();
    idle();
    mif.req1_vld  = 1'b1;
    mif.req1_src0 = 32'd9;
    mif.req1_src1 = 32'd9;
    mif.req1_func = 3'b100;
    mif.rsp1_rdy  = 1'b0;
    step();
    mif.req1_vld = 1'b0;
    mif.flush    = 1'b1;
    mid();
    checks++;
    if (mif.rsp1_vld !== 1'b1 || mif.rsp0_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush1_during got=%b%b exp=10",
               mif.rsp1_vld, mif.rsp0_vld);
    end
    step();
    mif.flush = 1'b0;
    mid();
    checks++;
    if (mif.rsp1_vld !== 1'b1 || mif.rsp_rslt !== 32'd81) begin
      errors++;
      $display("FAIL flush1_after got=%b/%h exp=1/51",
               mif.rsp1_vld, mif.rsp_rslt);
    end
    mif.rsp1_rdy = 1'b1;
    step();
    idle();
    step();
  endtask

  task automatic test_signed_high();
    idle();
    mif.req1_vld  = 1'b1;
    mif.req1_src0 = 32'hFFFF_FFFF;
    mif.req1_src1 = 32'h0000_0002;
    mif.req1_func = 3'b011;
    mid();
    checks++;
    if (mif.req1_rdy !== 1'b1 || mif.mul_ex1_func !== 3'b011) begin
      errors++;
      $display("FAIL sh_issue got=%b/%b exp=1/011",
               mif.req1_rdy, mif.mul_ex1_func);
    end
    step();
    idle();
    mid();
    checks++;
    if (mif.rsp1_vld !== 1'b1 || mif.rsp0_vld !== 1'b0) begin
      errors++;
      $display("FAIL sh_vld got=%b%b exp=10",
               mif.rsp1_vld, mif.rsp0_vld);
    end
    checks++;
    if (mif.rsp_rslt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sh_rslt got=%h exp=ffffffff", mif.rsp_rslt);
    end
    step();
  endtask

  task automatic test_mid_reset();
    idle();
    mif.req0_vld  = 1'b1;
    mif.req0_src0 = 32'd1;
    mif.req0_src1 = 32'd1;
    mif.req0_func = 3'b100;
    mif.req1_vld  = 1'b1;
    mif.req1_src0 = 32'd2;
    mif.req1_src1 = 32'd2;
    mif.req1_func = 3'b100;
    step();
    step();
    mif.rsp0_rdy = 1'b0;
    mid();
    checks++;
    if (dut.starve_cnt !== 4'd2 || mif.rsp0_vld !== 1'b1) begin
      errors++;
      $display("FAIL mr_pre got=%0d/%b exp=2/1",
               dut.starve_cnt, mif.rsp0_vld);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mif.req0_rdy, mif.req1_rdy, mif.mul_ex1_sel,
         mif.rsp0_vld, mif.rsp1_vld, mif.mul_ex2_stall}
        !== 6'b0) begin
      errors++;
      $display("FAIL mr_during got=%b%b%b%b%b%b exp=000000",
               mif.req0_rdy, mif.req1_rdy, mif.mul_ex1_sel,
               mif.rsp0_vld, mif.rsp1_vld, mif.mul_ex2_stall);
    end
    step();
    rst = 1'b0;
    idle();
    mif.req0_vld  = 1'b1;
    mif.req0_src0 = 32'd11;
    mif.req0_src1 = 32'd3;
    mif.req0_func = 3'b100;
    mid();
    checks++;
    if ({mif.rsp0_vld, mif.rsp1_vld, mif.mul_ex2_stall}
        !== 3'b0 || dut.starve_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mr_after got=%b%b%b/%0d exp=000/0",
               mif.rsp0_vld, mif.rsp1_vld, mif.mul_ex2_stall,
               dut.starve_cnt);
    end
    checks++;
    if (mif.req0_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mr_rdy0 got=%b exp=1", mif.req0_rdy);
    end
    step();
    idle();
    mid();
    checks++;
    if (mif.rsp0_vld !== 1'b1 || mif.rsp_rslt !== 32'd33) begin
      errors++;
      $display("FAIL mr_rslt got=%b/%h exp=1/21",
               mif.rsp0_vld, mif.rsp_rslt);
    end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle();
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_starvation();
    test_flush();
    test_signed_high();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
